// File: rtl/run_ctrl_pkg.sv
// Shared run-state encoding and default timing for the front-panel run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    PAUSED = 3'd2,
    HALTED = 3'd3,
    STEP   = 3'd4   // only reachable when single-step is built in
  } run_state_t;

  localparam int unsigned DB_CYCLES_DEF   = 500_000;
  localparam int unsigned STEP_CYCLES_DEF = 50_000_000;

  // States in which the divided CPU clock is held frozen
  function automatic logic is_frozen(run_state_t s);
    return (s == PAUSED) || (s == HALTED);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, one-cycle press pulse on accepted rise.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then accept a new level only after DB_CYCLES consecutive mismatching samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      btn_press <= 1'b0;
      if (sync2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        btn_level <= sync2;
        btn_press <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_run_ctrl.sv
// Front-panel run controller: debounced start/stop buttons and CPU halt request drive
// the divider's run_start / run_stop levels.
// Optional feature macro: BTN_RUN_SINGLE_STEP_EN (start while paused releases one divided period).
module btn_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       halt_req,
  output logic       run_start,
  output logic       run_stop,
  output logic [2:0] state_o
);

  run_state_t state_q;
  run_state_t state_d;
  logic       start_press;
  logic       stop_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_start),
    .btn_level (),
    .btn_press (start_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_stop),
    .btn_level (),
    .btn_press (stop_press)
  );

`ifdef BTN_RUN_SINGLE_STEP_EN
  localparam int unsigned STEP_W = (STEP_CYCLES > 0) ? $clog2(STEP_CYCLES + 1) : 1;

  logic [STEP_W-1:0] step_cnt;

  // Count cycles spent in STEP; restarts at zero on every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= '0;
    end else if ((state_q == STEP) && (state_d == STEP)) begin
      step_cnt <= step_cnt + STEP_W'(1);
    end else begin
      step_cnt <= '0;
    end
  end
`endif

  // Next-state logic: halt over stop over start; stop wins a simultaneous press
  always_comb begin
    state_d = state_q;
    if (halt_req) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        IDLE:    if (start_press && !stop_press) state_d = RUN;
        RUN:     if (stop_press) state_d = PAUSED;
`ifdef BTN_RUN_SINGLE_STEP_EN
        PAUSED:  if (start_press && !stop_press) state_d = STEP;
        STEP: begin
          if (stop_press) begin
            state_d = PAUSED;
          end else if (step_cnt == STEP_W'(STEP_CYCLES - 1)) begin
            state_d = PAUSED;
          end
        end
`else
        PAUSED:  if (start_press && !stop_press) state_d = RUN;
`endif
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers, outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      run_start <= 1'b0;
      run_stop  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_start <= run_start | (state_d != IDLE);
      run_stop  <= is_frozen(state_d);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_btn_run_ctrl.sv
// Self-checking bench for btn_run_ctrl with DB_CYCLES=4, STEP_CYCLES=8.
module tb_btn_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int unsigned DB   = 4;
  localparam int unsigned STEP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start;
  logic       btn_stop;
  logic       halt_req;
  logic       run_start;
  logic       run_stop;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic       rs;
    logic       rp;
  } exp_t;

  typedef struct {
    string      name;
    logic       start;
    logic       stop;
    logic       halt;
    int         cycles;
    logic [2:0] st;
    logic       rs;
    logic       rp;
  } vec_t;

  exp_t sb[$];

  btn_run_ctrl #(.DB_CYCLES(DB), .STEP_CYCLES(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .halt_req  (halt_req),
    .run_start (run_start),
    .run_stop  (run_stop),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string name, input run_state_t st, input logic rs, input logic rp);
    exp_t e;
    e.name = name;
    e.st   = 3'(st);
    e.rs   = rs;
    e.rp   = rp;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare with the outputs sampled now (at negedge)
  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      checks++;
      $display("FAIL scoreboard_empty: actual=0 entries required>=1");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (state_o !== e.st || run_start !== e.rs || run_stop !== e.rp) begin
      failures++;
      $display("FAIL %s: actual state=%0d run_start=%0b run_stop=%0b required state=%0d run_start=%0b run_stop=%0b",
               e.name, state_o, run_start, run_stop, e.st, e.rs, e.rp);
    end
  endtask

  // Drive inputs at a negedge, expect the result after n rising edges
  task automatic apply(input vec_t v);
    btn_start = v.start;
    btn_stop  = v.stop;
    halt_req  = v.halt;
    push_exp(v.name, run_state_t'(v.st), v.rs, v.rp);
    repeat (v.cycles) @(posedge clk);
    @(negedge clk);
    check_now();
  endtask

  task automatic press_release(input logic start, input logic stop, input string name,
                               input run_state_t st, input logic rs, input logic rp);
    vec_t v;
    v = '{name, start, stop, 1'b0, 10, 3'(st), rs, rp};
    apply(v);
    v = '{{name, "_rel"}, 1'b0, 1'b0, 1'b0, 10, 3'(st), rs, rp};
    apply(v);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    rst = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; halt_req = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_exp("reset_state", IDLE, 1'b0, 1'b0);
    check_now();

    // Bouncy start: toggles every 2 cycles for 20 cycles, never accepted
    for (int i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      repeat (2) @(negedge clk);
    end
    btn_start = 1'b0;
    repeat (8) @(negedge clk);
    push_exp("bounce_ignored", IDLE, 1'b0, 1'b0);
    check_now();

    // Table: stop in IDLE, start latency boundary, repeated presses, simultaneous press
    vecs.push_back('{"stop_in_idle",   1'b0, 1'b1, 1'b0, 10, 3'(IDLE),   1'b0, 1'b0});
    vecs.push_back('{"stop_idle_rel",  1'b0, 1'b0, 1'b0, 10, 3'(IDLE),   1'b0, 1'b0});
    vecs.push_back('{"start_6_cycles", 1'b1, 1'b0, 1'b0, 6,  3'(IDLE),   1'b0, 1'b0});
    vecs.push_back('{"start_7_cycles", 1'b1, 1'b0, 1'b0, 1,  3'(RUN),    1'b1, 1'b0});
    vecs.push_back('{"start_held",     1'b1, 1'b0, 1'b0, 10, 3'(RUN),    1'b1, 1'b0});
    vecs.push_back('{"start_release",  1'b0, 1'b0, 1'b0, 10, 3'(RUN),    1'b1, 1'b0});
    vecs.push_back('{"start_in_run",   1'b1, 1'b0, 1'b0, 10, 3'(RUN),    1'b1, 1'b0});
    vecs.push_back('{"start_run_rel",  1'b0, 1'b0, 1'b0, 10, 3'(RUN),    1'b1, 1'b0});
    vecs.push_back('{"both_pressed",   1'b1, 1'b1, 1'b0, 10, 3'(PAUSED), 1'b1, 1'b1});
    vecs.push_back('{"both_release",   1'b0, 1'b0, 1'b0, 10, 3'(PAUSED), 1'b1, 1'b1});
    vecs.push_back('{"stop_in_paused", 1'b0, 1'b1, 1'b0, 10, 3'(PAUSED), 1'b1, 1'b1});
    vecs.push_back('{"stop_pause_rel", 1'b0, 1'b0, 1'b0, 10, 3'(PAUSED), 1'b1, 1'b1});
    foreach (vecs[i]) apply(vecs[i]);

`ifdef BTN_RUN_SINGLE_STEP_EN
    // Start in PAUSED -> STEP, run_stop low for exactly STEP cycles
    v = '{"step_enter", 1'b1, 1'b0, 1'b0, 7, 3'(STEP), 1'b1, 1'b0};
    apply(v);
    for (int i = 1; i < int'(STEP); i++) begin
      v = '{"step_window", 1'b1, 1'b0, 1'b0, 1, 3'(STEP), 1'b1, 1'b0};
      apply(v);
    end
    v = '{"step_done", 1'b1, 1'b0, 1'b0, 1, 3'(PAUSED), 1'b1, 1'b1};
    apply(v);
    v = '{"step_held", 1'b1, 1'b0, 1'b0, 10, 3'(PAUSED), 1'b1, 1'b1};
    apply(v);
    v = '{"step_rel", 1'b0, 1'b0, 1'b0, 10, 3'(PAUSED), 1'b1, 1'b1};
    apply(v);
    // Stop during a step returns to PAUSED at once
    v = '{"step2_enter", 1'b1, 1'b0, 1'b0, 7, 3'(STEP), 1'b1, 1'b0};
    apply(v);
    v = '{"step2_rel", 1'b0, 1'b0, 1'b0, 1, 3'(STEP), 1'b1, 1'b0};
    apply(v);
    v = '{"stop_in_step", 1'b0, 1'b1, 1'b0, 7, 3'(PAUSED), 1'b1, 1'b1};
    apply(v);
    v = '{"stop_step_rel", 1'b0, 1'b0, 1'b0, 10, 3'(PAUSED), 1'b1, 1'b1};
    apply(v);
`else
    // Start in PAUSED resumes RUN
    press_release(1'b1, 1'b0, "resume_run", RUN, 1'b1, 1'b0);
`endif

    // One-cycle halt pulse
    v = '{"halt_pulse", 1'b0, 1'b0, 1'b1, 1, 3'(HALTED), 1'b1, 1'b1};
    apply(v);
    v = '{"halt_after", 1'b0, 1'b0, 1'b0, 3, 3'(HALTED), 1'b1, 1'b1};
    apply(v);
    press_release(1'b1, 1'b0, "start_in_halted", HALTED, 1'b1, 1'b1);

    // Reset mid-operation with a start press half-debounced
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    btn_start = 1'b0;
    push_exp("mid_op_reset", IDLE, 1'b0, 1'b0);
    check_now();
    v = '{"post_reset_idle", 1'b0, 1'b0, 1'b0, 10, 3'(IDLE), 1'b0, 1'b0};
    apply(v);
    press_release(1'b1, 1'b0, "post_reset_start", RUN, 1'b1, 1'b0);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: actual=%0d entries required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
